// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions for the pipelined bitwise logic unit.
package logic_unit_pkg;

  localparam int LU_OP_W = 3;

  typedef enum logic [LU_OP_W-1:0] {
    LU_AND   = 3'd0,
    LU_OR    = 3'd1,
    LU_XOR   = 3'd2,
    LU_XNOR  = 3'd3,
    LU_NAND  = 3'd4,
    LU_NOR   = 3'd5,
    LU_NOTA  = 3'd6,
    LU_PASSB = 3'd7
  } lu_op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise operation plus result flags (zero, odd parity, all-ones).
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [LU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   y,
  output logic               zero,
  output logic               parity,
  output logic               ones
);

  // Select the bitwise function; every opcode value is decoded.
  always_comb begin
    y = '0;
    case (lu_op_e'(op))
      LU_AND:   y = a & b;
      LU_OR:    y = a | b;
      LU_XOR:   y = a ^ b;
      LU_XNOR:  y = ~(a ^ b);
      LU_NAND:  y = ~(a & b);
      LU_NOR:   y = ~(a | b);
      LU_NOTA:  y = ~a;
      LU_PASSB: y = b;
    endcase
  end

  assign zero   = (y == '0);
  assign parity = ^y;
  assign ones   = &y;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined logic unit with an accumulator that can
// replace operand A. The accumulator is read and written in stage 2, so
// back-to-back accumulator operations chain without bubbles.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LU_OP_W-1:0] in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_use_acc,
  input  logic               in_acc_wr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_y,
  output logic               out_zero,
  output logic               out_parity,
  output logic               out_ones,
  output logic [WIDTH-1:0]   acc_q
);

  logic               r_vld_p1;
  logic [LU_OP_W-1:0] r_op_p1;
  logic [WIDTH-1:0]   r_a_p1;
  logic [WIDTH-1:0]   r_b_p1;
  logic               r_use_acc_p1;
  logic               r_acc_wr_p1;

  logic               r_vld_p2;
  logic [WIDTH-1:0]   r_y_p2;
  logic               r_zero_p2;
  logic               r_par_p2;
  logic               r_ones_p2;
  logic [WIDTH-1:0]   r_acc;

  logic               w_s2_en;
  logic               w_s1_en;
  logic               w_s2_load;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_y;
  logic               w_zero;
  logic               w_par;
  logic               w_ones;

  // Ready depends only on downstream state, never on in_valid.
  assign w_s2_en   = !r_vld_p2 || out_ready;
  assign w_s1_en   = !r_vld_p1 || w_s2_en;
  assign w_s2_load = w_s2_en && r_vld_p1;
  assign in_ready  = w_s1_en;

  // ---- stage 1: operand capture ----
  // S1 valid: loads on a transfer, clears when advancing without one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld_p1 <= 1'b0;
    else if (w_s1_en) r_vld_p1 <= in_valid;
  end

  // S1 payload is only meaningful while r_vld_p1 is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_s1_en && in_valid) begin
      r_op_p1      <= in_op;
      r_a_p1       <= in_a;
      r_b_p1       <= in_b;
      r_use_acc_p1 <= in_use_acc;
      r_acc_wr_p1  <= in_acc_wr;
    end
  end

  // ---- stage 2: compute, flag and register result ----
  assign w_a = r_use_acc_p1 ? r_acc : r_a_p1;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op     (r_op_p1),
    .a      (w_a),
    .b      (r_b_p1),
    .y      (w_y),
    .zero   (w_zero),
    .parity (w_par),
    .ones   (w_ones)
  );

  // Output register: holds under backpressure, drops valid when S1 is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2  <= 1'b0;
      r_y_p2    <= '0;
      r_zero_p2 <= 1'b1;
      r_par_p2  <= 1'b0;
      r_ones_p2 <= 1'b0;
    end else if (w_s2_en) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_y_p2    <= w_y;
        r_zero_p2 <= w_zero;
        r_par_p2  <= w_par;
        r_ones_p2 <= w_ones;
      end
    end
  end

  // Accumulator updates on the same edge that S2 loads an acc_wr transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_acc <= '0;
    else if (w_s2_load && r_acc_wr_p1) r_acc <= w_y;
  end

  assign out_valid  = r_vld_p2;
  assign out_y      = r_y_p2;
  assign out_zero   = r_zero_p2;
  assign out_parity = r_par_p2;
  assign out_ones   = r_ones_p2;
  assign acc_q      = r_acc;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and random checks of logic_unit_pipe at WIDTH = 1, 8 and 32.
// All three instances share stimulus; the handshake does not depend on data,
// so they advance in lockstep. Directed checks observe the 8-bit instance.
module tb_logic_unit_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_use_acc;
  logic        in_acc_wr;
  logic        out_ready;

  logic        rdy1, vld1, z1, p1, o1;
  logic [0:0]  y1, acc1;
  logic        rdy8, vld8, z8, p8, o8;
  logic [7:0]  y8, acc8;
  logic        rdy32, vld32, z32, p32, o32;
  logic [31:0] y32, acc32;

  int n_checks = 0;
  int n_errors = 0;

  logic_unit_pipe #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_op(in_op), .in_a(in_a[0:0]), .in_b(in_b[0:0]),
    .in_use_acc(in_use_acc), .in_acc_wr(in_acc_wr),
    .out_valid(vld1), .out_ready(out_ready), .out_y(y1),
    .out_zero(z1), .out_parity(p1), .out_ones(o1), .acc_q(acc1)
  );

  logic_unit_pipe #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .in_op(in_op), .in_a(in_a[7:0]), .in_b(in_b[7:0]),
    .in_use_acc(in_use_acc), .in_acc_wr(in_acc_wr),
    .out_valid(vld8), .out_ready(out_ready), .out_y(y8),
    .out_zero(z8), .out_parity(p8), .out_ones(o8), .acc_q(acc8)
  );

  logic_unit_pipe #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_use_acc(in_use_acc), .in_acc_wr(in_acc_wr),
    .out_valid(vld32), .out_ready(out_ready), .out_y(y32),
    .out_zero(z32), .out_parity(p32), .out_ones(o32), .acc_q(acc32)
  );

  // Per-width views used by the random scoreboard.
  logic        rdy_w[3], vld_w[3], z_w[3], p_w[3], o_w[3];
  logic [31:0] y_w[3], acc_w[3];
  logic [31:0] mask_w[3];

  assign rdy_w[0] = rdy1;  assign rdy_w[1] = rdy8;  assign rdy_w[2] = rdy32;
  assign vld_w[0] = vld1;  assign vld_w[1] = vld8;  assign vld_w[2] = vld32;
  assign z_w[0]   = z1;    assign z_w[1]   = z8;    assign z_w[2]   = z32;
  assign p_w[0]   = p1;    assign p_w[1]   = p8;    assign p_w[2]   = p32;
  assign o_w[0]   = o1;    assign o_w[1]   = o8;    assign o_w[2]   = o32;
  assign y_w[0]   = {31'd0, y1};
  assign y_w[1]   = {24'd0, y8};
  assign y_w[2]   = y32;
  assign acc_w[0] = {31'd0, acc1};
  assign acc_w[1] = {24'd0, acc8};
  assign acc_w[2] = acc32;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lu_ref(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a ^ b);
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~a;
      default: return b;
    endcase
  endfunction

  // Issue one transaction with out_ready high; returns with its result on the outputs.
  task automatic run_one(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; in_op = op; in_a = {24'd0, a}; in_b = {24'd0, b};
    in_use_acc = 1'b0; in_acc_wr = 1'b0; out_ready = 1'b1;
    #1;
    check("issue_rdy", rdy8, 1);
    step();
    in_valid = 1'b0;
    #1;
    check("lat_not_yet", vld8, 0);
    step();
    check("lat_vld", vld8, 1);
  endtask

  logic [7:0]  op_exp [8] = '{8'h24, 8'hBD, 8'h99, 8'h66, 8'hDB, 8'h42, 8'h5A, 8'h3C};
  logic [7:0]  bp_got [$];
  logic [31:0] sbq [3][$];
  logic [31:0] acc_m [3];

  initial begin
    int nxt;
    int accepted;
    int cyc;
    logic hold;
    logic [31:0] e;
    logic [31:0] v;

    mask_w[0] = 32'h1; mask_w[1] = 32'hFF; mask_w[2] = 32'hFFFF_FFFF;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0;
    in_use_acc = 1'b0; in_acc_wr = 1'b0; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    #1;
    check("rst_vld", vld8, 0);
    check("rst_y", y8, 8'h00);
    check("rst_zero", z8, 1);
    check("rst_par", p8, 0);
    check("rst_ones", o8, 0);
    check("rst_acc", acc8, 8'h00);
    check("rst_rdy", rdy8, 1);

    // All opcodes on A=A5, B=3C.
    for (int i = 0; i < 8; i++) begin
      run_one(i[2:0], 8'hA5, 8'h3C);
      check($sformatf("op%0d_y", i), y8, op_exp[i]);
      check($sformatf("op%0d_zero", i), z8, 0);
      check($sformatf("op%0d_par", i), p8, 0);
    end
    step();

    // Accumulator chain, back-to-back; in_a is garbage wherever use_acc is set.
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'd7; in_a = 32'h55; in_b = 32'h0F; in_use_acc = 1'b0; in_acc_wr = 1'b1;
    step();
    in_op = 3'd2; in_b = 32'hFF; in_use_acc = 1'b1;
    step();
    check("chain0_vld", vld8, 1);
    check("chain0_y", y8, 8'h0F);
    check("chain0_acc", acc8, 8'h0F);
    in_op = 3'd0; in_b = 32'h3C;
    step();
    check("chain1_vld", vld8, 1);
    check("chain1_y", y8, 8'hF0);
    check("chain1_acc", acc8, 8'hF0);
    in_valid = 1'b0; in_use_acc = 1'b0; in_acc_wr = 1'b0;
    step();
    check("chain2_vld", vld8, 1);
    check("chain2_y", y8, 8'h30);
    check("chain2_acc", acc8, 8'h30);
    step();

    // Backpressure: five cycles of out_ready low with in_valid high.
    out_ready = 1'b0; in_op = 3'd7; in_use_acc = 1'b0; in_acc_wr = 1'b0;
    in_valid = 1'b1; nxt = 0; in_b = 32'h10;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c >= 2) begin
        check("bp_rdy_low", rdy8, 0);
        check("bp_vld", vld8, 1);
        check("bp_y_hold", y8, 8'h10);
      end
      if (rdy8) nxt++;
      step();
      in_b = 32'h10 + nxt;
    end
    check("bp_accepts", nxt, 2);
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (vld8 && out_ready) bp_got.push_back(y8);
      if (in_valid && rdy8) nxt++;
      step();
      if (nxt >= 3) in_valid = 1'b0;
      else in_b = 32'h10 + nxt;
    end
    check("bp_count", bp_got.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("bp_order%0d", i), (i < bp_got.size()) ? bp_got[i] : 8'hXX, 8'h10 + i);

    // Flag edge cases.
    run_one(3'd0, 8'hFF, 8'hFF);
    check("ff_and_y", y8, 8'hFF);
    check("ff_and_ones", o8, 1);
    check("ff_and_par", p8, 0);
    check("ff_and_zero", z8, 0);
    run_one(3'd2, 8'h5A, 8'h5A);
    check("xeq_zero", z8, 1);
    check("xeq_ones", o8, 0);
    run_one(3'd7, 8'h00, 8'h01);
    check("b01_par", p8, 1);
    step();

    // Asynchronous reset in the middle of a burst.
    out_ready = 1'b1; in_valid = 1'b1; in_op = 3'd7; in_b = 32'h77;
    in_use_acc = 1'b0; in_acc_wr = 1'b1;
    step(); step();
    check("pre_rst_acc", acc8, 8'h77);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", vld8, 0);
    check("mid_rst_acc", acc8, 8'h00);
    check("mid_rst_zero", z8, 1);
    check("mid_rst_y", y8, 8'h00);
    in_valid = 1'b0; in_acc_wr = 1'b0;
    step(); step();
    rst_n = 1'b1;
    #1;
    check("post_rst_rdy", rdy8, 1);
    check("post_rst_vld", vld8, 0);
    step();
    check("post_rst_idle", vld8, 0);

    // Random valid/ready traffic with a scoreboard at all three widths.
    for (int k = 0; k < 3; k++) acc_m[k] = '0;
    accepted = 0; cyc = 0; hold = 1'b0;
    while (accepted < 10000 && cyc < 60000) begin
      if (!hold) begin
        in_valid   = ($urandom_range(0, 1) == 1);
        in_op      = 3'($urandom_range(0, 7));
        in_a       = $urandom;
        in_b       = $urandom;
        in_use_acc = ($urandom_range(0, 1) == 1);
        in_acc_wr  = ($urandom_range(0, 1) == 1);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (vld_w[k] && out_ready) begin
          if (sbq[k].size() == 0) begin
            check($sformatf("rnd%0d_spurious", k), 1, 0);
          end else begin
            e = sbq[k].pop_front();
            check($sformatf("rnd%0d_y", k), y_w[k], e);
            check($sformatf("rnd%0d_zero", k), z_w[k], (e == 0));
            check($sformatf("rnd%0d_par", k), p_w[k], ^e);
            check($sformatf("rnd%0d_ones", k), o_w[k], (e == mask_w[k]));
          end
        end
        if (in_valid && rdy_w[k]) begin
          v = lu_ref(in_op, in_use_acc ? acc_m[k] : (in_a & mask_w[k]), in_b & mask_w[k]) & mask_w[k];
          sbq[k].push_back(v);
          if (in_acc_wr) acc_m[k] = v;
        end
      end
      hold = in_valid && !rdy8;
      if (in_valid && rdy8) accepted++;
      cyc++;
      step();
    end
    check("rnd_budget", (accepted >= 10000), 1);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        if (vld_w[k] && out_ready) begin
          if (sbq[k].size() == 0) begin
            check($sformatf("drain%0d_spurious", k), 1, 0);
          end else begin
            e = sbq[k].pop_front();
            check($sformatf("drain%0d_y", k), y_w[k], e);
          end
        end
      end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rnd%0d_left", k), sbq[k].size(), 0);
      check($sformatf("rnd%0d_acc", k), acc_w[k], acc_m[k]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, two-stage pipelined bitwise logic unit. It is the successor to the team's fixed 4-bit XOR slice in the ALU datapath. It performs one of eight bitwise operations on WIDTH-bit operands, with an optional internal accumulator standing in for operand A. Results are delivered over valid/ready handshakes at input and output. It feeds the ALU result mux alongside the adder path.

## Interface
- WIDTH, 8, operand/result width in bits (≥1).
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low; one clock, async active-low reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  unit accepts input this cycle.
- in_op  in  3  operation code, lu_op_e.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_use_acc  in  1  1 = use accumulator as operand A; in_a is ignored.
- in_acc_wr  in  1  1 = write the result into the accumulator.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_y  out  WIDTH  result.
- out_zero  out  1  out_y == 0.
- out_parity  out  1  XOR-reduction of out_y (odd parity).
- out_ones  out  1  out_y is all ones.
- acc_q  out  WIDTH  current accumulator value.

## Operation
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR.
  - 6 NOTA: ~A.
  - 7 PASSB: B.
- Stage 1 (S1) registers op, a, b, use_acc and acc_wr, plus s1_valid.
- Stage 2 (S2) computes the result and flags and registers them into the out_* signals.
  - When use_acc is 1, S2 takes A from the accumulator.
  - When acc_wr is 1, the accumulator is written in the same cycle S2 loads.
  - Because S2 both reads and writes the accumulator, back-to-back accumulator operations see each other's results with no hazard and no bubble.
- Handshake:
  - s2_en = !out_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en.
  - A transfer occurs when valid && ready.
  - in_ready is combinational from out_valid and out_ready. There is no combinational path from in_valid to in_ready.
- Pipeline movement:
  - S2 loads from S1 when s2_en && s1_valid.
  - When s2_en && !s1_valid, out_valid drops to 0.
  - S1 loads on an input transfer. When s1_en without a transfer, s1_valid clears.
- Stall: while out_valid && !out_ready, out_* and acc_q hold. S1 holds if full, so at most two transactions are in flight.
- Producer rule: while in_valid && !in_ready, in_* must remain stable. The unit does not check this.
- Flags are computed from the S2 result and registered with out_y. They always correspond to the current out_y.
- Width rules: all operations are bitwise on WIDTH bits. No carry, no extension.

## Timing
- Reset values, applied immediately on rst_n low and independent of clk:
  - s1_valid = 0, out_valid = 0.
  - out_y = 0, out_zero = 1, out_parity = 0, out_ones = 0 (1 if WIDTH is irrelevant; WIDTH ≥ 1, so 0).
  - acc_q = 0.
- Latency: an input accepted at edge N appears with out_valid at edge N+1, when S2 is free.
- Throughput: one result per cycle with out_ready held high.
- Simultaneous pop and push: when S2 is full, out_ready = 1 and S1 is full, S2 takes S1 and S1 takes the new input in the same cycle.
- Reset mid-operation: in-flight transactions are discarded and the accumulator clears. The first cycle after deassertion has in_ready = 1.
- acc_q updates at the edge where S2 loads an acc_wr transaction. It is visible as acc_q in the next cycle.

## Structure
- logic_unit_pkg holds:
  - the typedef enum logic [2:0] lu_op_e with the opcode values above;
  - LU_OP_W = 3.
- Sub-module logic_unit_core: purely combinational.
  - Inputs: op, a, b.
  - Outputs: y, zero, parity, ones.
  - Parametrised by WIDTH and instantiated once in S2.
- The top level contains only the handshake logic, the S1 and S2 registers and the accumulator.

## Test plan
- Reset, WIDTH=8: hold rst_n low mid-burst, then release.
  - Immediately: out_valid = 0, acc_q = 0x00, out_zero = 1.
  - In the first cycle after release: in_ready = 1.
- All opcodes: A=0xA5, B=0x3C with out_ready = 1.
  - AND 0x24, OR 0xBD, XOR 0x99, XNOR 0x66, NAND 0xDB, NOR 0x42, NOTA 0x5A, PASSB 0x3C.
  - Each result arrives one cycle after acceptance.
  - Parity and zero flags must match each result.
- Accumulator chain, issued back-to-back:
  - PASSB B=0x0F with acc_wr.
  - XOR use_acc B=0xFF with acc_wr.
  - AND use_acc B=0x3C with acc_wr.
  - Required outputs: 0x0F, 0xF0, 0x30.
  - acc_q ends at 0x30, with no bubbles.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles with in_valid = 1.
  - in_ready falls after two acceptances. out_y is stable throughout.
  - Release out_ready: all values emerge in order, with no loss or duplicates.
- Random throughput: random in_valid and out_ready over 10k transactions at WIDTH = 1, 8 and 32.
  - Scoreboard matches a reference model including the accumulator.
- Flags edge cases:
  - A=0xFF, B=0xFF, AND gives out_ones = 1 and parity 0.
  - XOR of equal operands gives out_zero = 1.
